imm_gen_unit: RTL and testbench



---
 rtl/imm_gen_pkg.sv | 43 ++++
 rtl/imm_fmt_decode.sv | 30 +++
 rtl/imm_gen_unit.sv | 103 ++++++++++
 tb/tb_imm_gen_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module      : imm_gen_pkg
// Description : Opcodes, format codes and instruction field positions for the
//               20-bit unicycle core immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    localparam logic [3:0] OP_RALU   = 4'h0;
    localparam logic [3:0] OP_IALU   = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_LUI    = 4'h5;
    localparam logic [3:0] OP_JAL    = 4'h6;
    localparam logic [3:0] OP_JALR   = 4'h7;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 3;
    localparam int RD_LSB     = 4;
    localparam int RD_MSB     = 7;
    localparam int RS1_LSB    = 8;
    localparam int RS1_MSB    = 11;
    localparam int RS2_LSB    = 12;
    localparam int RS2_MSB    = 15;
    localparam int IMM_HI_LSB = 16;
    localparam int IMM_HI_MSB = 19;

endpackage

`default_nettype wire

// File: rtl/imm_fmt_decode.sv
// ============================================================================
// Module      : imm_fmt_decode
// Description : Combinational opcode to immediate-format decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_fmt_decode
    import imm_gen_pkg::*;
(
    input  logic [3:0] opcode,
    output fmt_e       fmt
);

    always_comb begin
        fmt = FMT_ILL;
        case (opcode)
            OP_RALU:                   fmt = FMT_R;
            OP_IALU, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                  fmt = FMT_S;
            OP_BRANCH:                 fmt = FMT_B;
            OP_LUI:                    fmt = FMT_U;
            OP_JAL:                    fmt = FMT_J;
            default:                   fmt = FMT_ILL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_unit.sv
// ============================================================================
// Module      : imm_gen_unit
// Description : Immediate extraction/sign-extension with registered copy of
//               immediate and format. Optional IMM_GEN_ILLEGAL_EN adds a
//               registered illegal-opcode flag (illegal_q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_unit
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic [DATA_WIDTH-1:0] imm_q,
    output logic [2:0]            fmt_q
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic                  illegal_q
`endif
);

    logic [19:0]           w_instr;
    fmt_e                  w_fmt;
    logic [DATA_WIDTH-1:0] w_imm;

    logic signed [7:0]     w_field_i;
    logic signed [7:0]     w_field_s;
    logic signed [8:0]     w_field_b;
    logic signed [19:0]    w_field_u;
    logic signed [12:0]    w_field_j;

    logic [DATA_WIDTH-1:0] r_imm;
    fmt_e                  r_fmt;

    assign w_instr = instruction[19:0];

    // Bits above the 20-bit instruction word carry no information.
    if (DATA_WIDTH > 20) begin : g_upper_unused
        logic w_unused_upper;
        assign w_unused_upper = ^instruction[DATA_WIDTH-1:20];
    end

    imm_fmt_decode u_fmt_decode (
        .opcode (w_instr[OPCODE_MSB:OPCODE_LSB]),
        .fmt    (w_fmt)
    );

    assign w_field_i = w_instr[IMM_HI_MSB:RS2_LSB];
    assign w_field_s = {w_instr[IMM_HI_MSB:IMM_HI_LSB], w_instr[RD_MSB:RD_LSB]};
    assign w_field_b = {w_instr[IMM_HI_MSB:IMM_HI_LSB], w_instr[RD_MSB:RD_LSB], 1'b0};
    assign w_field_u = {w_instr[IMM_HI_MSB:RS1_LSB], 8'h00};
    assign w_field_j = {w_instr[IMM_HI_MSB:RS2_LSB], w_instr[RS1_MSB:RS1_LSB], 1'b0};

    // Size casts of signed fields perform the sign extension to DATA_WIDTH.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = DATA_WIDTH'(w_field_i);
            FMT_S:   w_imm = DATA_WIDTH'(w_field_s);
            FMT_B:   w_imm = DATA_WIDTH'(w_field_b);
            FMT_U:   w_imm = DATA_WIDTH'(w_field_u);
            FMT_J:   w_imm = DATA_WIDTH'(w_field_j);
            default: w_imm = '0;
        endcase
    end

    assign immediate = w_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm <= '0;
            r_fmt <= FMT_R;
        end else begin
            r_imm <= w_imm;
            r_fmt <= w_fmt;
        end
    end

    assign imm_q = r_imm;
    assign fmt_q = r_fmt;

`ifdef IMM_GEN_ILLEGAL_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (w_fmt == FMT_ILL);
        end
    end

    assign illegal_q = r_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_unit.sv
// ============================================================================
// Module      : tb_imm_gen_unit
// Description : Self-checking bench for imm_gen_unit (table, reset, random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] instruction;
    logic [19:0] immediate;
    logic [19:0] imm_q;
    logic [2:0]  fmt_q;
`ifdef IMM_GEN_ILLEGAL_EN
    logic        illegal_q;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_unit #(.DATA_WIDTH(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .immediate   (immediate),
        .imm_q       (imm_q),
        .fmt_q       (fmt_q)
`ifdef IMM_GEN_ILLEGAL_EN
        ,
        .illegal_q   (illegal_q)
`endif
    );

    typedef struct {
        logic [19:0] ins;
        logic [19:0] imm;
        int          fmt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model computed from the format rules with integer arithmetic.
    function automatic int ref_fmt(input logic [19:0] ins);
        int op;
        op = int'(ins[3:0]);
        if (op == 0) return 0;
        if (op == 1 || op == 2 || op == 7) return 1;
        if (op == 3) return 2;
        if (op == 4) return 3;
        if (op == 5) return 4;
        if (op == 6) return 5;
        return 7;
    endfunction

    function automatic logic [19:0] ref_imm(input logic [19:0] ins);
        int f;
        int v;
        v = 0;
        case (ref_fmt(ins))
            1: begin
                f = int'(ins[19:12]);
                v = (f >= 128) ? f - 256 : f;
            end
            2: begin
                f = int'(ins[19:16]) * 16 + int'(ins[7:4]);
                v = (f >= 128) ? f - 256 : f;
            end
            3: begin
                f = int'(ins[19:16]) * 16 + int'(ins[7:4]);
                v = ((f >= 128) ? f - 256 : f) * 2;
            end
            4: v = int'(ins[19:8]) * 256;
            5: begin
                f = int'(ins[19:8]);
                v = ((f >= 2048) ? f - 4096 : f) * 2;
            end
            default: v = 0;
        endcase
        return v[19:0];
    endfunction

    task automatic apply(input string tag, input logic [19:0] ins,
                         input logic [19:0] eimm, input int efmt);
        @(negedge clk);
        instruction = ins;
        #1;
        check({tag, ".immediate"}, 32'(immediate), 32'(eimm));
        @(posedge clk);
        #1;
        check({tag, ".imm_q"}, 32'(imm_q), 32'(eimm));
        check({tag, ".fmt_q"}, 32'(fmt_q), 32'(efmt));
`ifdef IMM_GEN_ILLEGAL_EN
        check({tag, ".illegal_q"}, 32'(illegal_q), 32'(efmt == 7));
`endif
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{ins: 20'hFF321, imm: 20'hFFFFF, fmt: 1};
        vecs[1] = '{ins: 20'h05321, imm: 20'h00005, fmt: 1};
        vecs[2] = '{ins: 20'h802A3, imm: 20'hFFF8A, fmt: 2};
        vecs[3] = '{ins: 20'h01234, imm: 20'h00006, fmt: 3};
        vecs[4] = '{ins: 20'hABC15, imm: 20'hABC00, fmt: 4};
        vecs[5] = '{ins: 20'hFFF06, imm: 20'hFFFFE, fmt: 5};
        vecs[6] = '{ins: 20'h12340, imm: 20'h00000, fmt: 0};
        vecs[7] = '{ins: 20'h1234F, imm: 20'h00000, fmt: 7};
        vecs[8] = '{ins: 20'h80002, imm: 20'hFFF80, fmt: 1};
        vecs[9] = '{ins: 20'h7F0F4, imm: 20'h000FE, fmt: 3};

        // Reset asserted from time zero.
        rst_n       = 1'b0;
        instruction = 20'h05321;
        #2;
        check("reset.imm_q", 32'(imm_q), 32'h0);
        check("reset.fmt_q", 32'(fmt_q), 32'h0);
        check("reset.immediate", 32'(immediate), 32'h00005);
        @(posedge clk);
        #1;
        check("reset_edge.imm_q", 32'(imm_q), 32'h0);
`ifdef IMM_GEN_ILLEGAL_EN
        check("reset.illegal_q", 32'(illegal_q), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].ins, vecs[i].imm, vecs[i].fmt);
        end

        // Asynchronous reset pulse between edges, then recovery.
        apply("pre_rst", 20'h05321, 20'h00005, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.imm_q", 32'(imm_q), 32'h0);
        check("mid_rst.fmt_q", 32'(fmt_q), 32'h0);
        check("mid_rst.immediate", 32'(immediate), 32'h00005);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.imm_q", 32'(imm_q), 32'h00005);
        check("post_rst.fmt_q", 32'(fmt_q), 32'h1);

        // Illegal flag set then cleared by consecutive instructions.
        apply("ill_seq0", 20'hFFFF8, 20'h00000, 7);
        apply("ill_seq1", 20'hFFFF7, 20'hFFFFF, 1);

        for (int i = 0; i < 300; i++) begin
            logic [19:0] r;
            r = 20'($urandom);
            apply($sformatf("rand%0d", i), r, ref_imm(r), ref_fmt(r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
